// File: rtl/apb4_cmd_master.sv
// APB4 initiator: one valid/ready command becomes one APB4 transfer with a valid/ready response.
// Optional ACCESS-phase timeout is compiled in with `define APB4_MST_TIMEOUT_EN.
module apb4_cmd_master #(
   parameter int unsigned ADDR_WIDTH    = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned TIMEOUT_WIDTH = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic                      cmd_write_i,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr_i,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata_i,
   input  logic [DATA_WIDTH/8-1:0]   cmd_strb_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
   output logic                      rsp_err_o,
`ifdef APB4_MST_TIMEOUT_EN
   output logic                      rsp_timeout_o,
   input  logic [TIMEOUT_WIDTH-1:0]  cfg_timeout_i,
`endif
   output logic                      psel_o,
   output logic                      penable_o,
   output logic                      pwrite_o,
   output logic [ADDR_WIDTH-1:0]     paddr_o,
   output logic [DATA_WIDTH-1:0]     pwdata_o,
   output logic [DATA_WIDTH/8-1:0]   pstrb_o,
   output logic [2:0]                pprot_o,
   input  logic [DATA_WIDTH-1:0]     prdata_i,
   input  logic                      pready_i,
   input  logic                      pslverr_i
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   if ((DATA_WIDTH % 8 != 0) || (TIMEOUT_WIDTH == 0)) begin : g_bad_cfg
      $error("apb4_cmd_master: DATA_WIDTH must be a multiple of 8 and TIMEOUT_WIDTH nonzero");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RESP
   } state_t;

   state_t                  state, state_nxt;
   logic                    psel_nxt, penable_nxt, pwrite_nxt;
   logic [ADDR_WIDTH-1:0]   paddr_nxt;
   logic [DATA_WIDTH-1:0]   pwdata_nxt;
   logic [STRB_WIDTH-1:0]   pstrb_nxt;
   logic                    rsp_valid_nxt, rsp_err_nxt;
   logic [DATA_WIDTH-1:0]   rsp_rdata_nxt;

`ifdef APB4_MST_TIMEOUT_EN
   localparam logic [TIMEOUT_WIDTH-1:0] TO_ONE = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
   logic [TIMEOUT_WIDTH-1:0] wait_cnt, wait_cnt_nxt;
   logic                     rsp_timeout_nxt;
   logic                     timeout_hit;

   // Abort on the cfg_timeout_i-th ACCESS cycle that still sees no pready.
   assign timeout_hit = (cfg_timeout_i != '0) && (wait_cnt == cfg_timeout_i - TO_ONE);
`endif

   assign cmd_ready_o = (state == ST_IDLE);
   assign pprot_o     = 3'b000;

   always_comb begin
      state_nxt     = state;
      psel_nxt      = psel_o;
      penable_nxt   = penable_o;
      pwrite_nxt    = pwrite_o;
      paddr_nxt     = paddr_o;
      pwdata_nxt    = pwdata_o;
      pstrb_nxt     = pstrb_o;
      rsp_valid_nxt = rsp_valid_o;
      rsp_err_nxt   = rsp_err_o;
      rsp_rdata_nxt = rsp_rdata_o;
`ifdef APB4_MST_TIMEOUT_EN
      wait_cnt_nxt    = wait_cnt;
      rsp_timeout_nxt = rsp_timeout_o;
`endif
      unique case (state)
         ST_IDLE: begin
            if (cmd_valid_i) begin
               paddr_nxt   = cmd_addr_i;
               pwrite_nxt  = cmd_write_i;
               pwdata_nxt  = cmd_wdata_i;
               pstrb_nxt   = cmd_write_i ? cmd_strb_i : '0;
               psel_nxt    = 1'b1;
               penable_nxt = 1'b0;
               state_nxt   = ST_SETUP;
            end
         end
         ST_SETUP: begin
            penable_nxt = 1'b1;
`ifdef APB4_MST_TIMEOUT_EN
            wait_cnt_nxt = '0;
`endif
            state_nxt = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (pready_i) begin
               psel_nxt      = 1'b0;
               penable_nxt   = 1'b0;
               rsp_valid_nxt = 1'b1;
               rsp_rdata_nxt = pwrite_o ? '0 : prdata_i;
               rsp_err_nxt   = pslverr_i;
`ifdef APB4_MST_TIMEOUT_EN
               rsp_timeout_nxt = 1'b0;
`endif
               state_nxt     = ST_RESP;
            end
`ifdef APB4_MST_TIMEOUT_EN
            else if (timeout_hit) begin
               psel_nxt        = 1'b0;
               penable_nxt     = 1'b0;
               rsp_valid_nxt   = 1'b1;
               rsp_rdata_nxt   = '0;
               rsp_err_nxt     = 1'b1;
               rsp_timeout_nxt = 1'b1;
               state_nxt       = ST_RESP;
            end else if (wait_cnt != '1) begin
               wait_cnt_nxt = wait_cnt + TO_ONE;
            end
`endif
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               rsp_valid_nxt = 1'b0;
               state_nxt     = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= ST_IDLE;
         psel_o      <= 1'b0;
         penable_o   <= 1'b0;
         pwrite_o    <= 1'b0;
         paddr_o     <= '0;
         pwdata_o    <= '0;
         pstrb_o     <= '0;
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 1'b0;
         rsp_rdata_o <= '0;
`ifdef APB4_MST_TIMEOUT_EN
         wait_cnt      <= '0;
         rsp_timeout_o <= 1'b0;
`endif
      end else begin
         state       <= state_nxt;
         psel_o      <= psel_nxt;
         penable_o   <= penable_nxt;
         pwrite_o    <= pwrite_nxt;
         paddr_o     <= paddr_nxt;
         pwdata_o    <= pwdata_nxt;
         pstrb_o     <= pstrb_nxt;
         rsp_valid_o <= rsp_valid_nxt;
         rsp_err_o   <= rsp_err_nxt;
         rsp_rdata_o <= rsp_rdata_nxt;
`ifdef APB4_MST_TIMEOUT_EN
         wait_cnt      <= wait_cnt_nxt;
         rsp_timeout_o <= rsp_timeout_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_apb4_cmd_master.sv
// Bench for apb4_cmd_master: directed cases then randomized transfers against a transfer-level model.
// The timeout case and rsp_timeout checks are included when APB4_MST_TIMEOUT_EN is defined.
module tb_apb4_cmd_master;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;
   localparam int unsigned TW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [SW-1:0] cmd_strb;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata, prdata;
   logic [SW-1:0] pstrb;
   logic [2:0]    pprot;
   logic          pready, pslverr;
`ifdef APB4_MST_TIMEOUT_EN
   logic          rsp_timeout;
   logic [TW-1:0] cfg_timeout;
`endif

   int unsigned   total = 0;
   int unsigned   bad   = 0;
   logic [AW-1:0] last_addr;

   always #5 clk = ~clk;

   apb4_cmd_master #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_WIDTH (TW)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .cmd_valid_i   (cmd_valid),
      .cmd_ready_o   (cmd_ready),
      .cmd_write_i   (cmd_write),
      .cmd_addr_i    (cmd_addr),
      .cmd_wdata_i   (cmd_wdata),
      .cmd_strb_i    (cmd_strb),
      .rsp_valid_o   (rsp_valid),
      .rsp_ready_i   (rsp_ready),
      .rsp_rdata_o   (rsp_rdata),
      .rsp_err_o     (rsp_err),
`ifdef APB4_MST_TIMEOUT_EN
      .rsp_timeout_o (rsp_timeout),
      .cfg_timeout_i (cfg_timeout),
`endif
      .psel_o        (psel),
      .penable_o     (penable),
      .pwrite_o      (pwrite),
      .paddr_o       (paddr),
      .pwdata_o      (pwdata),
      .pstrb_o       (pstrb),
      .pprot_o       (pprot),
      .prdata_i      (prdata),
      .pready_i      (pready),
      .pslverr_i     (pslverr)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One complete transfer. waits = ACCESS cycles with pready low before the slave answers.
   task automatic do_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [SW-1:0] strb, input int unsigned waits,
                          input logic [DW-1:0] rdval, input logic serr,
                          input int unsigned rsp_dly, input int unsigned cfg);
      bit            abort;
      int unsigned   n_acc;
      logic [DW-1:0] exp_rd;
      logic          exp_err;
      abort = 1'b0;
`ifdef APB4_MST_TIMEOUT_EN
      cfg_timeout = TW'(cfg);
      abort = (cfg != 0) && (waits >= cfg);
`endif
      n_acc   = abort ? cfg : waits + 1;
      exp_rd  = (abort || wr) ? '0 : rdval;
      exp_err = abort ? 1'b1 : serr;

      check("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      cmd_strb  = strb;
      @(negedge clk);
      check("setup_psel", psel, 1);
      check("setup_penable", penable, 0);
      check("setup_paddr", paddr, addr);
      check("setup_pwrite", pwrite, wr);
      check("setup_pwdata", pwdata, wdata);
      check("setup_pstrb", pstrb, wr ? strb : '0);
      check("setup_cmd_ready", cmd_ready, 0);
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cmd_strb  = SW'($urandom);
      @(negedge clk);
      for (int i = 0; i < int'(n_acc); i++) begin
         check("access_sel_en", {psel, penable}, 2'b11);
         check("access_no_rsp", rsp_valid, 0);
         check("access_paddr", paddr, addr);
         check("access_pwrite", pwrite, wr);
         pready  = (i == int'(waits));
         prdata  = (i == int'(waits)) ? rdval : DW'($urandom);
         pslverr = (i == int'(waits)) ? serr : 1'($urandom);
         @(negedge clk);
      end
      pready  = 1'b0;
      pslverr = 1'($urandom);
      prdata  = $urandom;
      for (int d = 0; d <= int'(rsp_dly); d++) begin
         check("rsp_valid", rsp_valid, 1);
         check("rsp_rdata", rsp_rdata, exp_rd);
         check("rsp_err", rsp_err, exp_err);
`ifdef APB4_MST_TIMEOUT_EN
         check("rsp_timeout", rsp_timeout, abort);
`endif
         check("rsp_psel_low", {psel, penable}, 2'b00);
         check("rsp_cmd_ready", cmd_ready, 0);
         rsp_ready = (d == int'(rsp_dly));
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      check("post_rsp_valid", rsp_valid, 0);
      check("post_cmd_ready", cmd_ready, 1);
      check("post_paddr_held", paddr, addr);
      check("post_psel", psel, 0);
      last_addr = addr;
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_strb  = '0;
      rsp_ready = 1'b0;
      prdata    = '0;
      pready    = 1'b0;
      pslverr   = 1'b0;
`ifdef APB4_MST_TIMEOUT_EN
      cfg_timeout = '0;
`endif
      repeat (2) @(negedge clk);
      check("rst_psel", psel, 0);
      check("rst_penable", penable, 0);
      check("rst_pwrite", pwrite, 0);
      check("rst_paddr", paddr, 0);
      check("rst_pwdata", pwdata, 0);
      check("rst_pstrb", pstrb, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      check("pprot", pprot, 0);
      rst = 1'b0;
      @(negedge clk);

      do_xfer(1'b1, 32'h0, 32'h3, 4'hF, 0, 32'h0, 1'b0, 0, 0);
      do_xfer(1'b0, 32'h8, 32'h0, 4'hF, 2, 32'hA5, 1'b0, 0, 0);
      do_xfer(1'b1, 32'h4, 32'h1234_5678, 4'h5, 1, 32'hDEAD_BEEF, 1'b1, 0, 0);
      do_xfer(1'b0, 32'hC, 32'h0, 4'h0, 0, 32'h5A5A_0F0F, 1'b0, 5, 0);

      // Reset in the middle of ACCESS drops the transfer with no response.
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h44;
      cmd_wdata = 32'h77;
      cmd_strb  = 4'hF;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      check("rstmid_in_access", {psel, penable}, 2'b11);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rstmid_sel_en", {psel, penable}, 2'b00);
      check("rstmid_rsp_valid", rsp_valid, 0);
      check("rstmid_cmd_ready", cmd_ready, 1);
      pready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("rstmid_no_rsp", rsp_valid, 0);
         check("rstmid_idle_psel", psel, 0);
      end
      pready = 1'b0;
      last_addr = '0;

`ifdef APB4_MST_TIMEOUT_EN
      do_xfer(1'b0, 32'h10, 32'h0, 4'h0, 20, 32'h1111, 1'b0, 1, 4);
      do_xfer(1'b0, 32'h14, 32'h0, 4'h0, 3, 32'h2222, 1'b0, 0, 4);
      do_xfer(1'b1, 32'h18, 32'h9, 4'h3, 5, 32'h0, 1'b1, 0, 1);
`endif

      for (int n = 0; n < 60; n++) begin
         int unsigned gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < int'(gap); g++) begin
            @(negedge clk);
            check("gap_psel", psel, 0);
            check("gap_paddr_held", paddr, last_addr);
         end
         do_xfer(1'($urandom), {$urandom} & 32'hFFFF_FFFC, $urandom, SW'($urandom),
                 $urandom_range(0, 6), $urandom, ($urandom % 4) == 0,
                 $urandom_range(0, 3), $urandom_range(0, 6));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
